// File: rtl/pipe_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : pipe_ctrl_if
// Brief    : Hazard inputs and stage-register controls between datapath and pipe_ctrl.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_ctrl_if #(
   parameter int RADDR_W = 4
);
   logic [RADDR_W-1:0] id_rs1;
   logic [RADDR_W-1:0] id_rs2;
   logic               id_use_rs1;
   logic               id_use_rs2;
   logic               id_halt;
   logic [RADDR_W-1:0] ex_reg_write_addr;
   logic               ex_mem_to_reg;
   logic               ex_branch_taken;
   logic               mem_req;
   logic               pc_en;
   logic               ifid_en;
   logic               idex_en;
   logic               exmem_en;
   logic               memwb_en;
   logic               ifid_flush;
   logic               idex_flush;
   logic               mem_busy;
   logic               halted;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
      output ex_reg_write_addr, ex_mem_to_reg, ex_branch_taken, mem_req,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
      input  ifid_flush, idex_flush, mem_busy, halted
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
      input  ex_reg_write_addr, ex_mem_to_reg, ex_branch_taken, mem_req,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
      output ifid_flush, idex_flush, mem_busy, halted
   );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//------------------------------------------------------------------------------
// Module   : pipe_ctrl
// Brief    : TISC pipeline sequencer: memory freeze, load-use bubble, branch squash, halt drain.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl #(
   parameter int MEM_WAIT = 2,
   parameter int RADDR_W  = 4
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   pipe_ctrl_if.slave  bus
);

   localparam int c_CNT_W = ($clog2(MEM_WAIT + 1) > 1) ? $clog2(MEM_WAIT + 1) : 1;
   localparam bit c_HAS_WAIT = (MEM_WAIT > 0);
   localparam logic [c_CNT_W-1:0] c_CNT_LOAD = (MEM_WAIT > 0) ? c_CNT_W'(MEM_WAIT - 1) : '0;
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
   localparam logic [6:0] c_CTL_RUN   = 7'b11111_00;
   localparam logic [6:0] c_CTL_FRZ   = 7'b00000_00;
   localparam logic [6:0] c_CTL_BR    = 7'b11111_11;
   localparam logic [6:0] c_CTL_STALL = 7'b00111_01;
   localparam logic [6:0] c_CTL_RST   = 7'b00000_11;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_WAIT = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_ret_halt;

   logic [RADDR_W-1:0]   w_rs1;
   logic [RADDR_W-1:0]   w_rs2;
   logic [RADDR_W-1:0]   w_wa;
   logic                 w_lu;
   logic                 w_freeze;
   logic                 w_rr_halt;
   logic [6:0]           w_rr;
   logic [6:0]           w_ctl;
   logic                 w_busy;
   logic                 w_halted;

   assign w_rs1 = bus.id_rs1;
   assign w_rs2 = bus.id_rs2;
   assign w_wa  = bus.ex_reg_write_addr;

   assign w_lu = bus.ex_mem_to_reg &&
                 ((bus.id_use_rs1 && (w_rs1 == w_wa)) ||
                  (bus.id_use_rs2 && (w_rs2 == w_wa)));
   assign w_freeze  = c_HAS_WAIT && bus.mem_req;
   // The instruction in ID is wrong-path under a taken branch, so its hazards are moot.
   assign w_rr_halt = !bus.ex_branch_taken && !w_lu && bus.id_halt;

   always_comb begin
      w_rr = c_CTL_RUN;
      if (bus.ex_branch_taken) begin
         w_rr = c_CTL_BR;
      end else if (w_lu || bus.id_halt) begin
         w_rr = c_CTL_STALL;
      end
   end

   always_comb begin
      w_ctl    = c_CTL_RUN;
      w_busy   = 1'b0;
      w_halted = 1'b0;
      case (r_state)
         S_RUN: begin
            if (w_freeze) begin
               w_ctl  = c_CTL_FRZ;
               w_busy = 1'b1;
            end else begin
               w_ctl = w_rr;
            end
         end
         S_WAIT: begin
            w_halted = r_ret_halt;
            if (r_cnt != '0) begin
               w_ctl  = c_CTL_FRZ;
               w_busy = 1'b1;
            end else if (r_ret_halt) begin
               w_ctl = c_CTL_STALL;
            end else begin
               w_ctl = w_rr;
            end
         end
         S_HALT: begin
            w_halted = 1'b1;
            if (w_freeze) begin
               w_ctl  = c_CTL_FRZ;
               w_busy = 1'b1;
            end else begin
               w_ctl = c_CTL_STALL;
            end
         end
         default: w_ctl = c_CTL_RUN;
      endcase
      if (!rst_n) begin
         w_ctl    = c_CTL_RST;
         w_busy   = 1'b0;
         w_halted = 1'b0;
      end
   end

   assign {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
           bus.ifid_flush, bus.idex_flush} = w_ctl;
   assign bus.mem_busy = w_busy;
   assign bus.halted   = w_halted;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_RUN;
         r_cnt      <= '0;
         r_ret_halt <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_freeze) begin
                  r_state    <= S_WAIT;
                  r_cnt      <= c_CNT_LOAD;
                  r_ret_halt <= 1'b0;
               end else if (w_rr_halt) begin
                  r_state <= S_HALT;
               end
            end
            S_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - c_CNT_ONE;
               end else if (r_ret_halt || w_rr_halt) begin
                  r_state    <= S_HALT;
                  r_ret_halt <= 1'b0;
               end else begin
                  r_state <= S_RUN;
               end
            end
            S_HALT: begin
               // Drain-time memory access: freeze, then come back here still halted.
               if (w_freeze) begin
                  r_state    <= S_WAIT;
                  r_cnt      <= c_CNT_LOAD;
                  r_ret_halt <= 1'b1;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_pipe_ctrl
// Brief    : Self-checking bench for pipe_ctrl with a cycle-level behavioural model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_ctrl;

   localparam int MEM_WAIT = 2;
   localparam int RADDR_W  = 4;

   // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, mem_busy, halted}
   localparam logic [8:0] E_RUN   = 9'b11111_00_0_0;
   localparam logic [8:0] E_FRZ   = 9'b00000_00_1_0;
   localparam logic [8:0] E_FRZH  = 9'b00000_00_1_1;
   localparam logic [8:0] E_BR    = 9'b11111_11_0_0;
   localparam logic [8:0] E_STALL = 9'b00111_01_0_0;
   localparam logic [8:0] E_HALT  = 9'b00111_01_0_1;
   localparam logic [8:0] E_RST   = 9'b00000_11_0_0;

   logic clk;
   logic rst_n;
   logic [8:0] act;
   logic [8:0] m_exp;
   int n_tests;
   int n_fail;

   int m_wait_left;
   bit m_release;
   bit m_halted;

   pipe_ctrl_if #(.RADDR_W(RADDR_W)) bus ();

   pipe_ctrl #(.MEM_WAIT(MEM_WAIT), .RADDR_W(RADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                 bus.ifid_flush, bus.idex_flush, bus.mem_busy, bus.halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: counts remaining frozen cycles and remembers whether HALT was taken.
   task automatic m_eval(output logic [8:0] e);
      bit lu;
      lu = bus.ex_mem_to_reg &&
           ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_reg_write_addr) ||
            (bus.id_use_rs2 && bus.id_rs2 == bus.ex_reg_write_addr));
      if (!rst_n) begin
         e = E_RST;
         m_wait_left = 0;
         m_release = 0;
         m_halted = 0;
      end else if (m_wait_left > 0) begin
         e = m_halted ? E_FRZH : E_FRZ;
         m_wait_left = m_wait_left - 1;
         if (m_wait_left == 0) m_release = 1;
      end else if (!m_release && bus.mem_req && MEM_WAIT > 0) begin
         e = m_halted ? E_FRZH : E_FRZ;
         m_wait_left = MEM_WAIT - 1;
         m_release = (m_wait_left == 0);
      end else begin
         m_release = 0;
         if (m_halted) e = E_HALT;
         else if (bus.ex_branch_taken) e = E_BR;
         else if (lu) e = E_STALL;
         else if (bus.id_halt) begin
            e = E_STALL;
            m_halted = 1;
         end else e = E_RUN;
      end
   endtask

   task automatic apply(input logic rn, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic u1, input logic u2, input logic hlt,
                        input logic [3:0] wa, input logic m2r, input logic br,
                        input logic mreq);
      @(negedge clk);
      rst_n                 = rn;
      bus.id_rs1            = rs1;
      bus.id_rs2            = rs2;
      bus.id_use_rs1        = u1;
      bus.id_use_rs2        = u2;
      bus.id_halt           = hlt;
      bus.ex_reg_write_addr = wa;
      bus.ex_mem_to_reg     = m2r;
      bus.ex_branch_taken   = br;
      bus.mem_req           = mreq;
      #1;
      m_eval(m_exp);
   endtask

   task automatic quiet();
      apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         n_tests++;
         if (act !== E_RST) begin
            n_fail++;
            $display("FAIL reset_hold[%0d] got=%b want=%b", i, act, E_RST);
         end
      end
      quiet();
      n_tests++;
      if (act !== E_RUN) begin
         n_fail++;
         $display("FAIL reset_release got=%b want=%b", act, E_RUN);
      end
   endtask

   task automatic test_mem_wait();
      logic [8:0] want [4] = '{E_FRZ, E_FRZ, E_RUN, E_RUN};
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, (i < 3) ? 1'b1 : 1'b0);
         n_tests++;
         if (act !== want[i]) begin
            n_fail++;
            $display("FAIL mem_wait[%0d] got=%b want=%b", i, act, want[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] want [7] = '{E_FRZ, E_FRZ, E_RUN, E_FRZ, E_FRZ, E_RUN, E_RUN};
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, (i < 6) ? 1'b1 : 1'b0);
         n_tests++;
         if (act !== want[i]) begin
            n_fail++;
            $display("FAIL back_to_back[%0d] got=%b want=%b", i, act, want[i]);
         end
      end
   endtask

   task automatic test_load_use();
      apply(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (act !== E_STALL) begin
         n_fail++;
         $display("FAIL load_use_stall got=%b want=%b", act, E_STALL);
      end
      apply(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (act !== E_RUN) begin
         n_fail++;
         $display("FAIL load_use_bubble got=%b want=%b", act, E_RUN);
      end
      apply(1'b1, 4'd1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (act !== E_RUN) begin
         n_fail++;
         $display("FAIL load_use_unused_src got=%b want=%b", act, E_RUN);
      end
      apply(1'b1, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      n_tests++;
      if (act !== E_STALL) begin
         n_fail++;
         $display("FAIL load_use_r0 got=%b want=%b", act, E_STALL);
      end
   endtask

   task automatic test_branch_priority();
      apply(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (act !== E_BR) begin
         n_fail++;
         $display("FAIL branch_wins got=%b want=%b", act, E_BR);
      end
      quiet();
      n_tests++;
      if (act !== E_RUN) begin
         n_fail++;
         $display("FAIL branch_stays_run got=%b want=%b", act, E_RUN);
      end
   endtask

   task automatic test_branch_during_wait();
      logic [8:0] want [4] = '{E_FRZ, E_FRZ, E_BR, E_RUN};
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0,
               (i < 3) ? 1'b1 : 1'b0, (i < 3) ? 1'b1 : 1'b0);
         n_tests++;
         if (act !== want[i]) begin
            n_fail++;
            $display("FAIL branch_in_wait[%0d] got=%b want=%b", i, act, want[i]);
         end
      end
   endtask

   task automatic test_halt();
      logic [8:0] want [8] = '{E_STALL, E_HALT, E_FRZH, E_FRZH, E_HALT, E_HALT, E_RST, E_RUN};
      logic       mreq [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         apply((i == 6) ? 1'b0 : 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, (i == 0) ? 1'b1 : 1'b0,
               4'd0, 1'b0, 1'b0, mreq[i]);
         n_tests++;
         if (act !== want[i]) begin
            n_fail++;
            $display("FAIL halt_seq[%0d] got=%b want=%b", i, act, want[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         apply(($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0,
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom),
               ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
               4'($urandom_range(0, 3)), 1'($urandom),
               ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
         n_tests++;
         if (act !== m_exp) begin
            n_fail++;
            $display("FAIL random[%0d] got=%b want=%b", i, act, m_exp);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      m_wait_left = 0;
      m_release = 0;
      m_halted = 0;
      rst_n = 1'b0;
      bus.id_rs1 = '0;
      bus.id_rs2 = '0;
      bus.id_use_rs1 = 1'b0;
      bus.id_use_rs2 = 1'b0;
      bus.id_halt = 1'b0;
      bus.ex_reg_write_addr = '0;
      bus.ex_mem_to_reg = 1'b0;
      bus.ex_branch_taken = 1'b0;
      bus.mem_req = 1'b0;
      test_reset();
      test_mem_wait();
      test_back_to_back();
      test_load_use();
      test_branch_priority();
      test_branch_during_wait();
      test_halt();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 8-bit TISC core. Each cycle it computes the enable and flush controls for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It freezes the whole pipeline for data-memory wait states, inserts a bubble on load-use hazards, squashes wrong-path instructions on a taken branch, and drains the pipeline on a halt instruction. It sits beside the datapath; its outputs drive the `en` inputs and flush-to-bubble controls of the stage registers.

## Interface
- `MEM_WAIT`, default 2: data-memory wait cycles per access (0 = single-cycle memory, no freeze).
- `RADDR_W`, default 4: register address width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `id_rs1`, `id_rs2`  in  RADDR_W  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1  corresponding source is actually read.
- `id_halt`  in  1  instruction in ID is HALT.
- `ex_reg_write_addr`  in  RADDR_W  destination of the instruction in EX.
- `ex_mem_to_reg`  in  1  instruction in EX is a load.
- `ex_branch_taken`  in  1  instruction in EX is a resolved taken branch.
- `mem_req`  in  1  instruction in MEM accesses data memory (read or write).
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1  register load enables.
- `ifid_flush`, `idex_flush`  out  1  load a bubble (all control bits 0) instead of data.
- `mem_busy`  out  1  pipeline frozen for a memory wait state.
- `halted`  out  1  HALT has been accepted.

## Operation
- States: RUN, WAIT, HALT. A wait counter `cnt` has width max(1, clog2(MEM_WAIT+1)).
- All outputs are combinational from the state, `cnt` and the inputs.
- **Reset** (`rst_n`=0 at an edge): next state is RUN and `cnt`=0.
  - While `rst_n`=0, all `*_en`=0, `ifid_flush`=`idex_flush`=1, `mem_busy`=0, `halted`=0.
- **Freeze**: all enables=0, flushes=0, `mem_busy`=1.
- **RUN** evaluates the following in priority order:
  1. `mem_req`=1 and MEM_WAIT>0: freeze; `cnt`<=MEM_WAIT-1; go to WAIT.
  2. `ex_branch_taken`: all enables=1, `ifid_flush`=`idex_flush`=1. `id_halt` and load-use are ignored because the instruction in ID is wrong-path.
  3. Load-use: `ex_mem_to_reg` and ((`id_use_rs1` and `id_rs1`==`ex_reg_write_addr`) or (`id_use_rs2` and `id_rs2`==`ex_reg_write_addr`)).
     - `pc_en`=`ifid_en`=0, `idex_en`=1 with `idex_flush`=1, `exmem_en`=`memwb_en`=1.
     - Exactly one bubble per hazard, because the next cycle sees a bubble in EX.
  4. `id_halt`: `pc_en`=`ifid_en`=0, `idex_flush`=1, other enables=1; go to HALT.
  5. Otherwise all enables=1, flushes=0.
- **WAIT**:
  - `cnt`!=0: freeze; `cnt`<=`cnt`-1.
  - `cnt`==0: release. Outputs follow the RUN priorities 2–5 (`mem_req` is ignored because it belongs to the departing access). Next state is RUN, or HALT if rule 4 fires.
- **HALT**: `pc_en`=`ifid_en`=0, `idex_en`=1, `idex_flush`=1, `exmem_en`=`memwb_en`=1, `halted`=1.
  - Older instructions drain while bubbles fill the pipeline.
  - `mem_req` during the drain still freezes: the block runs the WAIT sequence and returns to HALT, holding `halted`=1.
  - Only reset exits HALT.
- Register address 0 gets no special treatment; a match on r0 still stalls.

## Timing
- Memory access: `mem_busy` is high for exactly MEM_WAIT consecutive cycles starting the cycle `mem_req` is first seen. The pipeline advances at the end of cycle MEM_WAIT+1. With MEM_WAIT=0, `mem_busy` never asserts.
- Back-to-back memory instructions each incur the full MEM_WAIT freeze. The release cycle never re-triggers on the departing access.
- Load-use costs 1 cycle. Taken branch costs 2 squashed slots, with no stall.
- `halted` rises the cycle after `id_halt` is accepted.
- Branch and load-use in the same cycle: branch wins, no stall.
- Hazard during a freeze: it is held and evaluated in the release cycle.
- Reset mid-WAIT or in HALT: state returns to RUN the next cycle. The bench checks reset outputs while `rst_n`=0.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with random inputs → all `*_en`=0, flushes=1, `halted`=0; after release with quiet inputs, all `*_en`=1.
- MEM_WAIT=2, `mem_req` for one load → `mem_busy`=1 in cycles 0–1, all enables 0; cycle 2 all enables 1. Two consecutive memory instructions → two separate 2-cycle freezes.
- Load-use: `ex_mem_to_reg`=1, `ex_reg_write_addr`=5, `id_rs2`=5, `id_use_rs2`=1 → one cycle `pc_en`=`ifid_en`=0, `idex_flush`=1; next cycle, with the EX bubble, all enables=1. Same with `id_use_rs2`=0 → no stall.
- `ex_branch_taken`=1 together with a load-use match and `id_halt` → `ifid_flush`=`idex_flush`=1, `pc_en`=1, state stays RUN.
- `id_halt` → `halted`=1 next cycle and persists; a `mem_req` during the drain gives a 2-cycle freeze with `halted` still 1; `rst_n`=0 for one edge → RUN, `halted`=0.
- Branch arriving during a WAIT freeze → flushes=0 while frozen; flushes assert exactly in the release cycle.
